core_seq: RTL
=============

# core_seq

Multi-cycle sequencer for the single-issue RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the strobes that share the register file, PC register and data-memory port across those phases. It sits beside the PC register, instruction memory and register file in the core top. It replaces the free-running PC increment with state-driven PC enables and traps on illegal opcodes or a stalled data memory.

## Interface
- `TIMEOUT`, default 15: maximum MEM-state cycles waiting for `dmem_ack` before a trap (1..255).
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst`  in  32  instruction-memory read data; valid the cycle after the PC changes (synchronous read).
- `br_taken`  in  1  ALU compare result, sampled in EXEC for branches.
- `dmem_ack`  in  1  data memory done; sampled only in MEM.
- `ir_load`  out  1  instruction register capture strobe.
- `pc_en`  out  1  PC register update strobe.
- `pc_sel`  out  2  PC source: 0 = pc+4, 1 = pc+imm (branch/JAL), 2 = rs1+imm (JALR).
- `alu_src`  out  1  1 = immediate operand B.
- `mem_to_reg`  out  2  writeback source: 0 = ALU, 1 = dmem, 2 = pc+4.
- `reg_write_ctl`  out  1  register-file write enable.
- `dmem_req`  out  1  data-memory request, held until ack.
- `dmem_we`  out  1  store when 1; valid while `dmem_req` = 1.
- `state`  out  3  current state code (debug).
- `trap`  out  1  core halted.
- `trap_cause`  out  2  1 = illegal opcode, 2 = dmem timeout, 0 = none.
- `retired`  out  32  count of retired instructions.

## Operation
- States and codes: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- FETCH: no strobes. Go to DECODE.
- DECODE: `ir_load` = 1. Latch `inst[6:0]` into `opcode_q` and `inst[11:7]` into `rd_q`.
  - Legal opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP.
  - Legal opcode: go to EXEC.
  - Any other opcode: go to TRAP with cause 1.
- EXEC: `alu_src` = 1 for OP-IMM, LOAD, STORE, JALR, LUI and AUIPC; 0 otherwise.
  - BRANCH: `pc_en` = 1, `pc_sel` = `br_taken` ? 1 : 0. Go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- MEM: `dmem_req` = 1, `dmem_we` = (STORE).
  - `dmem_ack` = 1 with STORE: `pc_en` = 1, `pc_sel` = 0, go to FETCH.
  - `dmem_ack` = 1 with LOAD: go to WB.
  - Wait counter increments each MEM cycle without ack. On the cycle the counter reaches `TIMEOUT`, go to TRAP with cause 2. An ack in that same cycle wins over the timeout.
  - The counter clears on entry to MEM.
- WB: `reg_write_ctl` = (`rd_q` != 0). `pc_en` = 1.
  - `mem_to_reg`: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 otherwise.
  - Go to FETCH.
- TRAP: all strobes 0. State held until reset. `trap` = 1 and `trap_cause` held.
- `retired` increments by 1 on every cycle with `pc_en` = 1 and wraps modulo 2^32.
- `dmem_ack` outside MEM is ignored.

## Timing
- Strobes are combinational from `state`, `opcode_q`, `rd_q` and, in EXEC only, `br_taken`. State, latches and counters are registered.
- Reset (asynchronous):
  - state = FETCH.
  - `opcode_q` and `rd_q` = 0.
  - Wait counter = 0, `retired` = 0.
  - `trap` = 0, `trap_cause` = 0.
  - All strobes = 0.
- Reset asserted mid-MEM drops `dmem_req` immediately, without waiting for a clock.
- Cycles per instruction (FETCH through last state):
  - BRANCH: 3.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - STORE: 4 + w.
  - LOAD: 5 + w.
  - w = MEM cycles before ack (w = 0 when ack arrives in the first MEM cycle).
- `pc_en` is asserted for exactly one cycle per instruction. The PC update lands on the same edge that enters FETCH.

## Test plan
- Reset, then feed `inst` = 0x00500093 (addi x1,x0,5): states 0,1,2,4,0; `reg_write_ctl` high only in cycle 4; `alu_src` = 1 in EXEC; `retired` = 1 after 4 cycles.
- BRANCH 0x00208463 with `br_taken` = 1: in EXEC `pc_en` = 1 and `pc_sel` = 1; back in FETCH after 3 cycles; no `reg_write_ctl`. Repeat with `br_taken` = 0: `pc_sel` = 0.
- LOAD 0x0000a103 with `dmem_ack` after 3 wait cycles: `dmem_req` high 4 cycles, `dmem_we` = 0; WB with `mem_to_reg` = 1; total 8 cycles.
- STORE, with `dmem_ack` never asserted and `TIMEOUT` = 15: TRAP after 15 MEM cycles, `trap_cause` = 2, `dmem_req` low after; `retired` unchanged.
- `inst` = 0xFFFFFFFF: TRAP entered from DECODE, `trap_cause` = 1, no `pc_en` ever after.
- JAL with `rd` = x0 (0x0000006F): WB has `reg_write_ctl` = 0, `pc_sel` = 1, `mem_to_reg` = 2. Assert `rst_n` low mid-MEM of a following load: `dmem_req` falls without a clock edge, state = 0.

Source files
------------

// File: rtl/core_seq_if.sv
// Data-memory handshake between the sequencer and the data-memory port.
// Ports: dmem_req/dmem_we (sequencer -> memory), dmem_ack (memory -> sequencer).
interface core_seq_if;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with trap on bad opcode or dmem stall.
// Ports: clk, rst_n, inst, br_taken, dmem (master), strobes, state, trap, trap_cause, retired.
module core_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    core_seq_if.master  dmem,
    output logic        ir_load,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        alu_src,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write_ctl,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t      state_q;
    logic [6:0]  opcode_q;
    logic [4:0]  rd_q;
    logic [7:0]  wait_q;
    logic [31:0] retired_q;
    logic        trap_q;
    logic [1:0]  cause_q;
    logic        req;
    logic        we;
    logic        unused_inst;

    // Only opcode and rd are latched; the datapath reads the rest of inst itself.
    assign unused_inst = ^inst[31:12];

    function automatic logic legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    endfunction

    logic is_br, is_ld, is_st, is_jal, is_jalr, is_imm_b;
    assign is_br    = (opcode_q == OP_BRANCH);
    assign is_ld    = (opcode_q == OP_LOAD);
    assign is_st    = (opcode_q == OP_STORE);
    assign is_jal   = (opcode_q == OP_JAL);
    assign is_jalr  = (opcode_q == OP_JALR);
    assign is_imm_b = (opcode_q == OP_IMM) || is_ld || is_st || is_jalr
                   || (opcode_q == OP_LUI) || (opcode_q == OP_AUIPC);

    always_comb begin
        ir_load       = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = 2'd0;
        alu_src       = 1'b0;
        mem_to_reg    = 2'd0;
        reg_write_ctl = 1'b0;
        req           = 1'b0;
        we            = 1'b0;
        unique case (state_q)
            S_FETCH: ;
            S_DECODE: ir_load = 1'b1;
            S_EXEC: begin
                alu_src = is_imm_b;
                if (is_br) begin
                    pc_en  = 1'b1;
                    pc_sel = br_taken ? 2'd1 : 2'd0;
                end
            end
            S_MEM: begin
                req = 1'b1;
                we  = is_st;
                if (dmem.dmem_ack && is_st)
                    pc_en = 1'b1;
            end
            S_WB: begin
                reg_write_ctl = (rd_q != 5'd0);
                pc_en         = 1'b1;
                mem_to_reg    = is_ld ? 2'd1 :
                                (is_jal || is_jalr) ? 2'd2 : 2'd0;
                pc_sel        = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
            end
            S_TRAP: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= 7'd0;
            rd_q      <= 5'd0;
            wait_q    <= 8'd0;
            retired_q <= 32'd0;
            trap_q    <= 1'b0;
            cause_q   <= 2'd0;
        end else begin
            if (pc_en)
                retired_q <= retired_q + 32'd1;
            unique case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    opcode_q <= inst[6:0];
                    rd_q     <= inst[11:7];
                    if (legal(inst[6:0])) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 2'd1;
                    end
                end
                S_EXEC: begin
                    if (is_br) begin
                        state_q <= S_FETCH;
                    end else if (is_ld || is_st) begin
                        state_q <= S_MEM;
                        wait_q  <= 8'd0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (dmem.dmem_ack) begin
                        state_q <= is_st ? S_FETCH : S_WB;
                    end else if (wait_q + 8'd1 == TMO) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 2'd2;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_WB: state_q <= S_FETCH;
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign dmem.dmem_req = req;
    assign dmem.dmem_we  = we;
    assign state         = state_q;
    assign trap          = trap_q;
    assign trap_cause    = cause_q;
    assign retired       = retired_q;

endmodule
